nios_system_sysid_arbiter: RTL
==============================

// Module: nios_system_sysid_arbiter
// PURPOSE
//  Shares the single system-ID control slave (1-bit address, 32-bit readdata) between two
//  requesters (req0 = Nios host bridge, req1 = boot-check engine). Round-robin arbitration,
//  one read per grant, programmable read latency, registered per-requester read data.
//  Compares each ID-word read against EXPECTED_ID and raises a sticky id_mismatch flag.
// PARAMETERS
//  READ_LATENCY  1             cycles sysid_address is held before readdata is sampled (1..15)
//  EXPECTED_ID   32'hF0F0F0F0  value required at sysid address 0 (system ID word)
// PORTS
//  clock           in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  req0            in   1   requester 0 read request, held high until ack0
//  addr0           in   1   requester 0 word select: 0 = ID, 1 = timestamp
//  ack0            out  1   one-cycle completion pulse to requester 0
//  rdata0          out  32  requester 0 read data; valid on ack0, held until next ack0
//  req1            in   1   requester 1 read request
//  addr1           in   1   requester 1 word select
//  ack1            out  1   one-cycle completion pulse to requester 1
//  rdata1          out  32  requester 1 read data
//  sysid_address   out  1   address to the system-ID slave
//  sysid_readdata  in   32  read data from the system-ID slave
//  busy            out  1   high whenever state != IDLE
//  id_mismatch     out  1   sticky: an address-0 read returned a value != EXPECTED_ID
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, ack0/ack1=0, rdata0/rdata1=0, sysid_address=0, busy=0,
//   id_mismatch=0, last_grant=1 (so req0 wins the first contested arbitration), lat_cnt=0.
//  FSM: IDLE -> ADDR -> RESP -> IDLE.
//  IDLE: if exactly one req high, grant it. If both high, grant the port != last_grant.
//   On grant, latch gnt_id and gnt_addr, set last_grant=gnt_id, load lat_cnt=READ_LATENCY-1,
//   and go to ADDR.
//  ADDR: sysid_address=gnt_addr (0 in every other state). Stay while lat_cnt!=0, decrementing
//   by 1 each cycle. On the cycle lat_cnt==0: capture sysid_readdata into rdata[gnt_id]; if
//   gnt_addr==0 and data!=EXPECTED_ID, set id_mismatch; then go to RESP.
//  RESP: ack[gnt_id]=1 for exactly this cycle; the other ack stays 0; go to IDLE.
//  Latency: req sampled in IDLE at cycle T -> ack at T+1+READ_LATENCY.
//   Throughput: one read per READ_LATENCY+2 cycles.
//  Requests are sampled only in IDLE. A req still high in the cycle after its ack is treated
//   as a new request. Round robin guarantees alternation when both requesters are held high.
//  A req dropped after grant does not abort: the read completes and the ack still pulses.
//   addr changes after grant are ignored (gnt_addr is latched).
//  rdata of the non-granted port never changes. rdata is updated only at capture.
//  id_mismatch is cleared only by reset. Timestamp reads (addr=1) never affect it.
//  Reset mid-transaction: return to the reset state immediately; no ack is issued for the
//   aborted read; rdata registers are cleared.
//  lat_cnt is 4 bits. READ_LATENCY outside 1..15 is unsupported. Use an elaboration-time
//   check to enforce this.
// TESTING
//  1 Slave model: addr0 -> F0F0F0F0, addr1 -> 543F392E. req0=1, addr0=0 at T, READ_LATENCY=1
//    -> ack0 at T+2, rdata0=F0F0F0F0, id_mismatch=0, ack1 never high.
//  2 req0 and req1 both raised at T and held (addr0=0, addr1=1) -> ack0 at T+2, ack1 at T+5,
//    ack0 at T+8, alternating. rdata1=543F392E.
//  3 Slave model returns 12345678 at addr 0; req1 reads addr 0 -> rdata1=12345678 and
//    id_mismatch=1 from the ack cycle onward, held through later good reads until reset.
//  4 READ_LATENCY=4: req0 addr=1 at T -> sysid_address=1 during T+1..T+4, ack0 at T+5,
//    busy high T+1..T+5.
//  5 reset pulsed during ADDR of a req1 read -> next cycle busy=0, sysid_address=0,
//    rdata1=0, no ack1 for that read. A fresh req1 then completes normally.
//  6 req0 dropped to 0 one cycle after grant, addr0 toggled -> ack0 still pulses at T+2 with
//    data for the originally latched address.

Source files
------------

// File: rtl/nios_system_sysid_arbiter.sv
// Round-robin arbiter sharing the system-ID slave between two requesters, with
// programmable read latency, per-requester read data and a sticky ID-mismatch flag.
module nios_system_sysid_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] EXPECTED_ID  = 32'hF0F0F0F0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        addr0,
    output logic        ack0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        addr1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        id_mismatch
);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
            $error("READ_LATENCY must be in the range 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    state_t      state_reg;
    state_t      state_next;
    logic        gnt_id_reg;
    logic        gnt_addr_reg;
    logic        last_grant_reg;
    logic [3:0]  lat_cnt_reg;
    logic        id_mismatch_reg;
    logic [31:0] rdata_reg [2];
    logic [1:0]  req_vec;
    logic [1:0]  ack_vec;
    logic        grant_valid;
    logic        grant_id;
    logic        grant_addr;
    logic        capture;

    assign req_vec     = {req1, req0};
    assign grant_valid = |req_vec;
    // On contention the port that did not win last time gets the slave.
    assign grant_id    = (&req_vec) ? ~last_grant_reg : req1;
    assign grant_addr  = grant_id ? addr1 : addr0;
    assign capture     = (state_reg == ADDR) && (lat_cnt_reg == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ADDR;
            ADDR:    if (lat_cnt_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_vec       = 2'b00;
        sysid_address = 1'b0;
        busy          = (state_reg != IDLE);
        if (state_reg == ADDR) begin
            sysid_address = gnt_addr_reg;
        end
        if (state_reg == RESP) begin
            ack_vec[gnt_id_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_id_reg      <= 1'b0;
            gnt_addr_reg    <= 1'b0;
            last_grant_reg  <= 1'b1;
            lat_cnt_reg     <= 4'd0;
            id_mismatch_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && grant_valid) begin
                gnt_id_reg     <= grant_id;
                gnt_addr_reg   <= grant_addr;
                last_grant_reg <= grant_id;
                lat_cnt_reg    <= LAT_LOAD;
            end else if (state_reg == ADDR && lat_cnt_reg != 4'd0) begin
                lat_cnt_reg <= lat_cnt_reg - 4'd1;
            end
            // Only the ID word is checked; timestamp reads never touch the flag.
            if (capture && !gnt_addr_reg && sysid_readdata != EXPECTED_ID) begin
                id_mismatch_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clock) begin
                if (reset) begin
                    rdata_reg[gi] <= 32'd0;
                end else if (capture && gnt_id_reg == 1'(gi)) begin
                    rdata_reg[gi] <= sysid_readdata;
                end
            end
        end
    endgenerate

    assign ack0        = ack_vec[0];
    assign ack1        = ack_vec[1];
    assign rdata0      = rdata_reg[0];
    assign rdata1      = rdata_reg[1];
    assign id_mismatch = id_mismatch_reg;

endmodule
